// File: rtl/gate_eval_arbiter.sv
// rtl/gate_eval_arbiter.sv - round-robin arbiter in front of a shared x | ~y evaluation unit
// Optional feature macro: GATE_EVAL_TIMEOUT_EN (DONE-state timeout on a stuck winner)
module gate_eval_arbiter #(
  parameter int N         = 4,
  parameter int TO_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         x,
  input  logic [N-1:0]         y,
  output logic [N-1:0]         gnt,
  output logic                 z,
  output logic                 z_valid,
  output logic [$clog2(N)-1:0] z_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  win_q, win_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           z_q, z_d;
  logic           zv_q, zv_d;
  logic [IW-1:0]  zid_q, zid_d;
  logic           busy_q, busy_d;

  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic [IW-1:0]  cand;

`ifdef GATE_EVAL_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           to_q, to_d;
`endif

  // Round-robin pick: scan upward from last_winner+1, wrapping; i == N lands back on last_winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int i = 1; i <= N; i++) begin
      cand = last_q + IW'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs are precomputed so they are registered in the state they describe.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt_d   = '0;
    z_d     = z_q;
    zv_d    = 1'b0;
    zid_d   = zid_q;
    busy_d  = busy_q;
`ifdef GATE_EVAL_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          // Operands are captured here as the finished result, so later x/y/req changes cannot reach z.
          win_d   = pick_idx;
          z_d     = x[pick_idx] | ~y[pick_idx];
          zv_d    = 1'b1;
          zid_d   = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          busy_d  = 1'b1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        last_d  = win_q;
        busy_d  = 1'b1;
        state_d = S_DONE;
`ifdef GATE_EVAL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_DONE: begin
        if (!req[win_q]) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
`ifdef GATE_EVAL_TIMEOUT_EN
        else if (cnt_q == CW'(TO_CYCLES - 1)) begin
          // last_winner is left alone so the stuck requester drops to lowest priority.
          to_d    = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once, abandoning any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      z_q     <= 1'b0;
      zv_q    <= 1'b0;
      zid_q   <= '0;
      busy_q  <= 1'b0;
`ifdef GATE_EVAL_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      z_q     <= z_d;
      zv_q    <= zv_d;
      zid_q   <= zid_d;
      busy_q  <= busy_d;
`ifdef GATE_EVAL_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign z       = z_q;
  assign z_valid = zv_q;
  assign z_id    = zid_q;
  assign busy    = busy_q;
`ifdef GATE_EVAL_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// tb/tb_gate_eval_arbiter.sv - directed self-checking bench for gate_eval_arbiter
module tb_gate_eval_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic [N-1:0] gnt;
  logic         z;
  logic         z_valid;
  logic [1:0]   z_id;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  gate_eval_arbiter #(.N(N), .TO_CYCLES(16)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .x       (x),
    .y       (y),
    .gnt     (gnt),
    .z       (z),
    .z_valid (z_valid),
    .z_id    (z_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; x = '0; y = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  int           ids[$];
  int           cyc_at[$];
  int           exp_ids[5] = '{0, 1, 2, 3, 0};
  int           rearm_cnt;
  int           rearm_id;
  int           cyc;
  int           to_seen;
  int           busy_cnt;

  initial begin
    // Reset state
    resetn = 1'b0;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_zv", 32'(z_valid), 32'h0);
    chk("rst_z", 32'(z), 32'h0);
    chk("rst_zid", 32'(z_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_to", 32'(timeout), 32'h0);
    do_reset();

    // Scenario 1: single requester 0, x=1 y=1 -> z=1
    req = 4'b0001; x = 4'b0001; y = 4'b0001;
    @(negedge clk);
    chk("s1_zv", 32'(z_valid), 32'h1);
    chk("s1_z", 32'(z), 32'h1);
    chk("s1_zid", 32'(z_id), 32'h0);
    chk("s1_gnt", 32'(gnt), 32'h1);
    busy_cnt = int'(busy);
    req = 4'b0000;
    @(negedge clk);
    chk("s1_zv_done", 32'(z_valid), 32'h0);
    chk("s1_gnt_done", 32'(gnt), 32'h0);
    busy_cnt += int'(busy);
    @(negedge clk);
    busy_cnt += int'(busy);
    chk("s1_busy_cycles", 32'(busy_cnt), 32'd2);
    chk("s1_z_hold", 32'(z), 32'h1);

    // Scenario 2: requester 1, x=0 y=1 -> z=0; then x=0 y=0 -> z=1
    req = 4'b0010; x = 4'b0000; y = 4'b0010;
    @(negedge clk);
    chk("s2a_z", 32'(z), 32'h0);
    chk("s2a_zid", 32'(z_id), 32'h1);
    chk("s2a_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    req = 4'b0010; x = 4'b0000; y = 4'b0000;
    @(negedge clk);
    chk("s2b_zv", 32'(z_valid), 32'h1);
    chk("s2b_z", 32'(z), 32'h1);
    chk("s2b_zid", 32'(z_id), 32'h1);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Scenario 3: all four request; each drops after its grant and re-requests while idle
    do_reset();
    req = 4'b1111; x = '0; y = '0;
    rearm_cnt = 0; rearm_id = 0;
    ids.delete(); cyc_at.delete();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        chk("s3_onehot", 32'($countones(gnt)), 32'd1);
        ids.push_back(int'(z_id));
        cyc_at.push_back(c);
        req[z_id] = 1'b0;
        rearm_id = int'(z_id);
        rearm_cnt = 2;
      end else if (rearm_cnt > 0) begin
        rearm_cnt--;
        if (rearm_cnt == 0) req[rearm_id] = 1'b1;
      end
    end
    chk("s3_ngrants", 32'(ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < ids.size(); i++) begin
      chk($sformatf("s3_order%0d", i), 32'(ids[i]), 32'(exp_ids[i]));
      if (i > 0) chk($sformatf("s3_gap%0d", i), 32'(cyc_at[i] - cyc_at[i-1]), 32'd3);
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Scenario 4: winner 2 changes operands and drops req right after the sample
    do_reset();
    req = 4'b0100; x = 4'b0000; y = 4'b0000;
    @(negedge clk);
    req = 4'b0000; x = 4'b0000; y = 4'b0100;
    #1;
    chk("s4_z_eval", 32'(z), 32'h1);
    chk("s4_zid", 32'(z_id), 32'h2);
    @(negedge clk);
    chk("s4_busy_done", 32'(busy), 32'h1);
    chk("s4_z_done", 32'(z), 32'h1);
    @(negedge clk);
    chk("s4_busy_idle", 32'(busy), 32'h0);

    // Scenario 5: reset asserted during EVAL clears outputs at once
    do_reset();
    req = 4'b0001; x = 4'b0001; y = 4'b0000;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("s5_zv", 32'(z_valid), 32'h0);
    chk("s5_gnt", 32'(gnt), 32'h0);
    chk("s5_z", 32'(z), 32'h0);
    chk("s5_busy", 32'(busy), 32'h0);
    req = '0; x = '0;
    @(negedge clk);
    chk("s5_zv_held", 32'(z_valid), 32'h0);
    resetn = 1'b1;
    req = 4'b0100; x = 4'b0100;
    @(negedge clk);
    chk("s5_post_gnt", 32'(gnt), 32'h4);
    chk("s5_post_zid", 32'(z_id), 32'h2);
    chk("s5_post_zv", 32'(z_valid), 32'h1);
    req = '0;
    repeat (2) @(negedge clk);

    // Scenario 6: requester 0 never releases
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    chk("s6_gnt", 32'(gnt), 32'h1);
`ifdef GATE_EVAL_TIMEOUT_EN
    to_seen = 0;
    cyc = 0;
    for (int c = 2; c <= 30 && to_seen == 0; c++) begin
      @(negedge clk);
      if (timeout) begin
        to_seen = 1;
        cyc = c;
      end
    end
    chk("s6_to_seen", 32'(to_seen), 32'h1);
    chk("s6_to_cycle", 32'(cyc), 32'd18);
    chk("s6_busy_after_to", 32'(busy), 32'h0);
    req = 4'b0011;
    @(negedge clk);
    chk("s6_to_pulse", 32'(timeout), 32'h0);
    chk("s6_next_gnt", 32'(gnt), 32'h2);
    req = '0;
    repeat (2) @(negedge clk);
`else
    to_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (timeout) to_seen++;
    end
    chk("s6_no_timeout", 32'(to_seen), 32'h0);
    chk("s6_still_busy", 32'(busy), 32'h1);
    req = '0;
    repeat (2) @(negedge clk);
    chk("s6_release_idle", 32'(busy), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
